// File: rtl/writeback_queue.sv
`default_nettype none
// ============================================================================
// Module      : writeback_queue
// Description : In-order writeback FIFO that feeds the register-file write
//               port. Each cycle it drains one entry into registered write
//               outputs. It also offers a combinational bypass lookup so that
//               decode can read values that are queued but not yet written.
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_queue #(
   parameter int XLEN  = 64,
   parameter int AW    = 5,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [AW-1:0]              in_rd,
   input  logic [XLEN-1:0]            in_data,
   output logic                       reg_write,
   output logic [AW-1:0]              rd,
   output logic [XLEN-1:0]            write_data,
   input  logic [AW-1:0]              rs1,
   input  logic [AW-1:0]              rs2,
   output logic                       fwd1_hit,
   output logic [XLEN-1:0]            fwd1_data,
   output logic                       fwd2_hit,
   output logic [XLEN-1:0]            fwd2_data,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [AW-1:0]   rd_mem   [DEPTH];
   logic [XLEN-1:0] data_mem [DEPTH];
   logic [PW-1:0]   head;
   logic [PW-1:0]   tail;
   logic            push;
   logic            pop;

   // Ready depends on occupancy only; writes to x0 are accepted but not stored.
   assign in_ready = (count != CW'(DEPTH));
   assign push     = in_valid & in_ready & (in_rd != '0);
   assign pop      = (count != '0);

   // Storage array; stale contents are harmless because count gates validity.
   always_ff @(posedge clk) begin
      if (push) begin
         rd_mem[tail]   <= in_rd;
         data_mem[tail] <= in_data;
      end
   end

   // Pointers, occupancy and the registered regfile write port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head       <= '0;
         tail       <= '0;
         count      <= '0;
         reg_write  <= 1'b0;
         rd         <= '0;
         write_data <= '0;
      end else begin
         if (push) begin
            tail <= tail + 1'b1;
         end
         if (pop) begin
            head       <= head + 1'b1;
            reg_write  <= 1'b1;
            rd         <= rd_mem[head];
            write_data <= data_mem[head];
         end else begin
            reg_write  <= 1'b0;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Scan candidates oldest to youngest so the youngest match overwrites.
   function automatic logic [XLEN:0] lookup(input logic [AW-1:0] src);
      logic            hit;
      logic [XLEN-1:0] val;
      logic [PW-1:0]   idx;
      hit = 1'b0;
      val = '0;
      if (src != '0) begin
         if (reg_write && (rd == src)) begin
            hit = 1'b1;
            val = write_data;
         end
         for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if ((CW'(i) < count) && (rd_mem[idx] == src)) begin
               hit = 1'b1;
               val = data_mem[idx];
            end
         end
      end
      return {hit, val};
   endfunction

   // Bypass lookups for both decode source operands.
   always_comb begin
      {fwd1_hit, fwd1_data} = lookup(rs1);
      {fwd2_hit, fwd2_data} = lookup(rs2);
   end

endmodule
`default_nettype wire

// File: tb/tb_writeback_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_writeback_queue
// Description : Directed self-checking bench for writeback_queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_writeback_queue;

   localparam int XLEN  = 64;
   localparam int AW    = 5;
   localparam int DEPTH = 4;

   logic            clk;
   logic            rst_n;
   logic            in_valid;
   logic            in_ready;
   logic [AW-1:0]   in_rd;
   logic [XLEN-1:0] in_data;
   logic            reg_write;
   logic [AW-1:0]   rd;
   logic [XLEN-1:0] write_data;
   logic [AW-1:0]   rs1;
   logic [AW-1:0]   rs2;
   logic            fwd1_hit;
   logic [XLEN-1:0] fwd1_data;
   logic            fwd2_hit;
   logic [XLEN-1:0] fwd2_data;
   logic [2:0]      count;

   int checks = 0;
   int errors = 0;

   writeback_queue #(.XLEN(XLEN), .AW(AW), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_rd      (in_rd),
      .in_data    (in_data),
      .reg_write  (reg_write),
      .rd         (rd),
      .write_data (write_data),
      .rs1        (rs1),
      .rs2        (rs2),
      .fwd1_hit   (fwd1_hit),
      .fwd1_data  (fwd1_data),
      .fwd2_hit   (fwd2_hit),
      .fwd2_data  (fwd2_data),
      .count      (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_rd    = '0;
      in_data  = '0;
      rs1      = 5'd5;
      rs2      = 5'd7;
      #2;
      check("rst_reg_write", 64'(reg_write), 64'd0);
      check("rst_count", 64'(count), 64'd0);
      check("rst_rd", 64'(rd), 64'd0);
      check("rst_wdata", write_data, 64'd0);
      step();
      rst_n = 1'b1;

      // 1. idle
      for (int i = 0; i < 5; i++) begin
         step();
         check("idle_reg_write", 64'(reg_write), 64'd0);
         check("idle_count", 64'(count), 64'd0);
         check("idle_ready", 64'(in_ready), 64'd1);
         check("idle_fwd1", 64'(fwd1_hit), 64'd0);
         check("idle_fwd2", 64'(fwd2_hit), 64'd0);
      end

      // 2. single push rd=5 data=-7
      in_valid = 1'b1; in_rd = 5'd5; in_data = -64'sd7;
      step();
      in_valid = 1'b0;
      check("single_count1", 64'(count), 64'd1);
      check("single_no_write_yet", 64'(reg_write), 64'd0);
      check("single_fwd1_hit", 64'(fwd1_hit), 64'd1);
      check("single_fwd1_data", fwd1_data, 64'hFFFF_FFFF_FFFF_FFF9);
      step();
      check("single_reg_write", 64'(reg_write), 64'd1);
      check("single_rd", 64'(rd), 64'd5);
      check("single_wdata", write_data, 64'hFFFF_FFFF_FFFF_FFF9);
      check("single_count0", 64'(count), 64'd0);
      step();
      check("single_done", 64'(reg_write), 64'd0);
      check("single_rd_hold", 64'(rd), 64'd5);
      check("single_wdata_hold", write_data, 64'hFFFF_FFFF_FFFF_FFF9);

      // 3. six back-to-back pushes with continuous drain
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1; in_rd = 5'(10 + i); in_data = 64'(i * 100 + 1);
         step();
         check("b2b_count", 64'(count), 64'd1);
         if (i > 0) begin
            check("b2b_reg_write", 64'(reg_write), 64'd1);
            check("b2b_rd", 64'(rd), 64'(10 + i - 1));
            check("b2b_wdata", write_data, 64'((i - 1) * 100 + 1));
         end
      end
      in_valid = 1'b0;
      step();
      check("b2b_last_rd", 64'(rd), 64'd15);
      check("b2b_last_wdata", write_data, 64'd501);
      check("b2b_last_count", 64'(count), 64'd0);
      step();
      check("b2b_drained", 64'(reg_write), 64'd0);

      // 4. pointer wrap with drain active: rd=1,2,3,4,1
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; in_rd = 5'((i % 4) + 1); in_data = 64'h1000 + 64'(i);
         check("wrap_ready", 64'(in_ready), 64'd1);
         step();
         check("wrap_count", 64'(count), 64'd1);
         if (i > 0) begin
            check("wrap_rd", 64'(rd), 64'(((i - 1) % 4) + 1));
            check("wrap_wdata", write_data, 64'h1000 + 64'(i - 1));
         end
      end
      in_valid = 1'b0;
      step();
      check("wrap_last_rd", 64'(rd), 64'd1);
      check("wrap_last_wdata", write_data, 64'h1004);
      step();
      check("wrap_drained", 64'(reg_write), 64'd0);

      // 5. bypass youngest-wins
      rs1 = 5'd3; rs2 = 5'd0;
      in_valid = 1'b1; in_rd = 5'd3; in_data = 64'd10;
      step();
      check("byp_first_data", fwd1_data, 64'd10);
      in_rd = 5'd3; in_data = 64'd20;
      step();
      in_valid = 1'b0;
      check("byp_fwd1_hit", 64'(fwd1_hit), 64'd1);
      check("byp_fwd1_data", fwd1_data, 64'd20);
      check("byp_fwd2_hit", 64'(fwd2_hit), 64'd0);
      check("byp_fwd2_data", fwd2_data, 64'd0);
      step();
      check("byp_outreg_hit", 64'(fwd1_hit), 64'd1);
      check("byp_outreg_data", fwd1_data, 64'd20);
      step();
      check("byp_drained_hit", 64'(fwd1_hit), 64'd0);
      check("byp_drained_data", fwd1_data, 64'd0);

      // 6. write to x0 discarded, then mid-operation reset
      in_valid = 1'b1; in_rd = 5'd0; in_data = 64'd99;
      check("x0_ready", 64'(in_ready), 64'd1);
      step();
      in_valid = 1'b0;
      check("x0_count", 64'(count), 64'd0);
      step();
      check("x0_no_write", 64'(reg_write), 64'd0);
      in_valid = 1'b1; in_rd = 5'd7; in_data = 64'd55;
      step();
      in_rd = 5'd8; in_data = 64'd66;
      step();
      in_valid = 1'b0;
      check("pre_rst_reg_write", 64'(reg_write), 64'd1);
      check("pre_rst_count", 64'(count), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_reg_write", 64'(reg_write), 64'd0);
      check("mid_rst_count", 64'(count), 64'd0);
      check("mid_rst_rd", 64'(rd), 64'd0);
      check("mid_rst_wdata", write_data, 64'd0);
      check("mid_rst_ready", 64'(in_ready), 64'd1);
      step();
      rst_n = 1'b1;
      step();
      check("post_rst_reg_write", 64'(reg_write), 64'd0);
      check("post_rst_count", 64'(count), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
